// File: rtl/lsu_mem_access_if.sv
// Request/response and data-memory bus signals of the load/store unit.
// slave is the LSU's view; master is the EXU plus memory side.
interface lsu_mem_access_if #(
  parameter int BITS   = 64,
  parameter int ADDR_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wen;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [BITS-1:0]   req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [BITS-1:0]   rsp_rdata;
  logic              rsp_err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [BITS-1:0]   mem_wdata;
  logic [7:0]        mem_wmask;
  logic              mem_ack;
  logic [BITS-1:0]   mem_rdata;

  modport slave (
    input  req_valid, req_wen, req_funct3, req_addr, req_wdata, rsp_ready, mem_ack, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
  );

  modport master (
    output req_valid, req_wen, req_funct3, req_addr, req_wdata, rsp_ready, mem_ack, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/lsu_mem_access.sv
// Load/store unit: one data-memory transaction per EXU request, with store lane alignment and load extension.
// Define LSU_MISALIGN_TRAP_EN to report misaligned accesses on rsp_err instead of force-aligning them.
module lsu_mem_access #(
  parameter int BITS   = 64,
  parameter int ADDR_W = 64
) (
  input logic             clk,
  input logic             rst_n,
  lsu_mem_access_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t            state;
  state_t            state_next;
  logic              accept;
  logic              go_resp;
  logic [2:0]        lane;
  logic [7:0]        size_mask;
  logic [BITS-1:0]   shifted;
  logic [BITS-1:0]   load_data;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [2:0]        lane_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [BITS-1:0]   mem_wdata_q;
  logic [7:0]        mem_wmask_q;
  logic [BITS-1:0]   rdata_q;

  assign accept = (state == IDLE) && bus.req_valid;

  // Lane offset is the address rounded down to the access size.
  always_comb begin
    size_mask = 8'h01;
    lane      = bus.req_addr[2:0];
    case (bus.req_funct3[1:0])
      2'b01: begin size_mask = 8'h03; lane = {bus.req_addr[2:1], 1'b0}; end
      2'b10: begin size_mask = 8'h0F; lane = {bus.req_addr[2], 2'b00}; end
      2'b11: begin size_mask = 8'hFF; lane = 3'b000; end
      default: ;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned;
  logic err_q;

  assign misaligned  = (lane != bus.req_addr[2:0]);
  assign go_resp     = misaligned;
  assign bus.rsp_err = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      err_q <= 1'b0;
    else if (accept) err_q <= misaligned;
  end
`else
  assign go_resp     = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.req_valid) state_next = go_resp ? RESP : BUS;
      BUS:     if (bus.mem_ack)   state_next = RESP;
      RESP:    if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state == IDLE);
    bus.mem_req   = (state == BUS);
    bus.rsp_valid = (state == RESP);
    bus.mem_we    = (state == BUS) && we_q;
    bus.mem_addr  = mem_addr_q;
    bus.mem_wdata = mem_wdata_q;
    bus.mem_wmask = mem_wmask_q;
    bus.rsp_rdata = rdata_q;
  end

  // funct3 011 and 111 both take the whole word.
  always_comb begin
    shifted = bus.mem_rdata >> {lane_q, 3'b000};
    case (funct3_q)
      3'b000:  load_data = {{(BITS-8){shifted[7]}},   shifted[7:0]};
      3'b001:  load_data = {{(BITS-16){shifted[15]}}, shifted[15:0]};
      3'b010:  load_data = {{(BITS-32){shifted[31]}}, shifted[31:0]};
      3'b100:  load_data = {{(BITS-8){1'b0}},  shifted[7:0]};
      3'b101:  load_data = {{(BITS-16){1'b0}}, shifted[15:0]};
      3'b110:  load_data = {{(BITS-32){1'b0}}, shifted[31:0]};
      default: load_data = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      lane_q      <= 3'b000;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= 8'h00;
      rdata_q     <= '0;
    end else if (accept) begin
      we_q        <= bus.req_wen;
      funct3_q    <= bus.req_funct3;
      lane_q      <= lane;
      mem_addr_q  <= {bus.req_addr[ADDR_W-1:3], 3'b000};
      mem_wdata_q <= bus.req_wdata << {lane, 3'b000};
      mem_wmask_q <= bus.req_wen ? (size_mask << lane) : 8'h00;
      rdata_q     <= '0;
    end else if ((state == BUS) && bus.mem_ack) begin
      rdata_q     <= we_q ? '0 : load_data;
    end
  end

endmodule
